// File: rtl/dds_sample_packer.sv
// Packs PACK_N strobed samples into one DCFIFO word, holding one word across back-pressure.
// Optional: define PARTIAL_FLUSH_EN to emit zero-padded partial words on a frame marker.
module dds_sample_packer #(
  parameter int SAMPLE_W = 8,
  parameter int PACK_N   = 4,
  parameter int OVF_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       en_i,
  input  logic                       dds_i,
  input  logic                       dds1_i,
  input  logic [SAMPLE_W-1:0]        sample_i,
  input  logic                       fifo_full_i,
  output logic                       fifo_wrreq_o,
  output logic [SAMPLE_W*PACK_N-1:0] fifo_data_o,
  output logic [OVF_W-1:0]           ovf_cnt_o,
  output logic                       busy_o
);
  localparam int WORD_W = SAMPLE_W * PACK_N;
  localparam int SLOT_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;

  typedef enum logic [1:0] {IDLE, PACK, HOLD} state_t;

  state_t              state_q;
  logic                dds_q, dds1_q;
  logic [SLOT_W-1:0]   slot_q, slot_a, slot_d;
  logic [WORD_W-1:0]   pack_q, pack_a, pack_d;
  logic [WORD_W-1:0]   hold_q, data_q, cword;
  logic [OVF_W-1:0]    ovf_q;
  logic                wrreq_q, busy_q;
  logic                tick, fmark, act, cmpl, flush;

  assign tick  = dds_i & ~dds_q;
  assign fmark = dds1_i & ~dds1_q;
  assign act   = en_i && (state_q != IDLE);

  // Lane capture; the pack register is cleared whenever a word leaves it,
  // so unfilled upper lanes of a partial word are always zero.
  always_comb begin
    slot_a = slot_q;
    pack_a = pack_q;
    if (fmark) begin
      slot_a = '0;
      pack_a = '0;
    end
    flush = 1'b0;
`ifdef PARTIAL_FLUSH_EN
    flush = act && fmark && (slot_q != '0);
`endif
    slot_d = slot_a;
    pack_d = pack_a;
    cmpl   = 1'b0;
    cword  = pack_q;
    if (act && tick) begin
      pack_d[slot_a*SAMPLE_W +: SAMPLE_W] = sample_i;
      if (slot_a == SLOT_W'(PACK_N-1)) begin
        cmpl   = 1'b1;
        cword  = pack_d;
        slot_d = '0;
        pack_d = '0;
      end else begin
        slot_d = slot_a + SLOT_W'(1);
      end
    end
    // With PACK_N > 1 a flush and a tick-completion cannot coincide.
    if (flush) begin
      cmpl  = 1'b1;
      cword = pack_q;
    end
    if (!act) begin
      slot_d = '0;
      pack_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      dds_q   <= 1'b0;
      dds1_q  <= 1'b0;
      slot_q  <= '0;
      pack_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      ovf_q   <= '0;
      wrreq_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dds_q   <= dds_i;
      dds1_q  <= dds1_i;
      slot_q  <= slot_d;
      pack_q  <= pack_d;
      wrreq_q <= 1'b0;
      case (state_q)
        IDLE: if (en_i) state_q <= PACK;
        PACK: begin
          if (!en_i) begin
            state_q <= IDLE;
          end else if (cmpl) begin
            if (!fifo_full_i) begin
              wrreq_q <= 1'b1;
              data_q  <= cword;
            end else begin
              hold_q  <= cword;
              busy_q  <= 1'b1;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!fifo_full_i) begin
            wrreq_q <= 1'b1;
            data_q  <= hold_q;
            if (cmpl) begin
              hold_q <= cword;
            end else begin
              busy_q  <= 1'b0;
              state_q <= en_i ? PACK : IDLE;
            end
          end else if (cmpl && (ovf_q != '1)) begin
            ovf_q <= ovf_q + OVF_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wrreq_o = wrreq_q;
  assign fifo_data_o  = data_q;
  assign ovf_cnt_o    = ovf_q;
  assign busy_o       = busy_q;
endmodule
